cf_sram_ctrl: RTL
=================

# cf_sram_ctrl

Single-port controller that drives the CF_SRAM_1024x32 macro from a valid/ready request channel and returns read data on a valid/ready response channel. It converts byte strobes to the macro's per-bit enables and ties off test/scan/power pins. It holds one read response under backpressure. It sits between the SoC bus adapter and each SRAM instance, sharing the macro's clock.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; STRB_W = DATA_W/8 derived

Ports:
- clk  in  1  clock, also drives the macro's CLKin
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high at a rising edge
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  STRB_W  byte-lane write enables
- rsp_valid  out  1  read data present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_W  read data
- init_done  out  1  SRAM usable
- sram_en, sram_r_wb  out  1  macro EN, R_WB
- sram_ad  out  ADDR_W  macro AD
- sram_ben  out  DATA_W  macro BEN
- sram_di  out  DATA_W  macro DI
- sram_do  in  DATA_W  macro DO
- sram_wlbi, sram_sm, sram_tm, sram_scan_dr, sram_scan_dl, sram_scan_cc  out  1  constant 0
- sram_vpwrac, sram_vpwrpc  out  1  constant 1

## Operation
- Accept = req_valid && req_ready. Macro command is combinational from the request in the accept cycle, so the macro samples it at the accept edge.
- On accept: sram_en=1, sram_r_wb=!req_we, sram_ad=req_addr, sram_di=req_wdata.
- sram_ben: byte i = {8{req_wstrb[i]}} on writes; all zero on reads.
- When there is no accept: sram_en=0, sram_r_wb=1, sram_ad=0, sram_di=0, sram_ben=0.
- Writes produce no response.
- A write with wstrb=0 is accepted, asserts EN, and changes no memory bits.
- Read accept sets rsp_valid at that edge.
- rsp_rdata = sram_do, passed through combinationally. DO is stable because no further read reaches the macro while rsp_valid is unconsumed.
- req_ready = init_done && (!rsp_valid || rsp_ready). Writes are also blocked during a response stall.
- Same-edge pop and read accept: rsp_valid stays 1 and the data is the new read's.
- Pop without a new read accept: rsp_valid goes to 0.
- States: INIT (macro enabled only) and RUN. Response holding is a single flag, rsp_valid.

## Timing
- Read latency: rsp_valid is high in the cycle after the accept edge, i.e. 1 cycle.
- Sustained throughput: 1 read per cycle while rsp_ready=1.
- Write takes effect at the accept edge. A read accepted in the next cycle returns the new data.
- Reset values: rsp_valid=0. All sram_* at idle values.
- init_done reset value: 0 with the macro defined, 1 without it.
- req_ready follows its equation: 0 throughout INIT; with the macro undefined it may be 1 in the first cycle after reset.
- rst asserted while a response is pending drops the response: rsp_valid=0 after the reset edge.

## Configuration
- CF_SRAM_CTRL_INIT_EN defined:
  - After rst deasserts, the INIT state writes zero to addresses 0..1023, one per cycle.
  - Each sweep write drives sram_en=1, r_wb=0, ben=all ones, di=0.
  - Address 0 is written in cycle 0 after reset; address 1023 in cycle 1023.
  - init_done=1 and state=RUN from cycle 1024.
  - req_ready=0 throughout INIT.
  - rst mid-sweep restarts the sweep at address 0.
- CF_SRAM_CTRL_INIT_EN undefined: no INIT state, init_done tied to 1, SRAM contents undefined after power-up.

## Structure
- Package cf_sram_ctrl_pkg holds:
  - constants ADDR_W, DATA_W, DEPTH=1024
  - state enum {INIT, RUN}
  - function strb_to_ben(strb) returning the per-bit enable mask
- One sub-module, cf_sram_init_seq, instantiated only under the macro. It contains the 10-bit sweep counter and a done flag, and outputs the sweep command and init_done. The top level muxes its command onto the sram_* outputs while in INIT.

## Test plan
- Write 0xDEADBEEF to addr 5 with strb 0xF, then read addr 5 -> sram_ben=0xFFFFFFFF on the write; rsp_valid one cycle after the read accept with rsp_rdata=0xDEADBEEF.
- Addr 7 holds 0xAABBCCDD; write 0x11223344 with strb 0b0101 -> sram_ben=0x00FF00FF; a following read of addr 7 returns 0xAA22CC44.
- Read addr 5 with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 for those cycles; raise rsp_ready -> pop, req_ready=1.
- Back-to-back reads of addrs 1,2,3 with rsp_ready=1 -> rsp_valid high 3 consecutive cycles, data in address order, req_ready never drops.
- Macro on: release rst -> req_ready=0 for cycles 0..1023 and init_done=1 at cycle 1024; read of addr 1023 returns 0.
- Macro on, reset mid-sweep: assert rst at cycle 500 -> sweep restarts at addr 0 and init_done rises 1024 cycles after release.
- Reset during a pending read: assert rst while rsp_valid=1, rsp_ready=0 -> rsp_valid=0 after the reset edge and no stale response follows.

Source files
------------

// File: rtl/cf_sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cf_sram_ctrl_pkg
// Shared constants, state type and the byte-strobe to bit-enable helper for the
// CF_SRAM_1024x32 controller (cf_sram_ctrl) and its init sweep sub-block.
// -----------------------------------------------------------------------------
package cf_sram_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1024;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Expand each byte strobe into eight per-bit enables for the macro's BEN pins.
  function automatic logic [DATA_W-1:0] strb_to_ben(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] ben;
    ben = '0;
    for (int i = 0; i < STRB_W; i++) begin
      ben[i*8 +: 8] = {8{strb[i]}};
    end
    return ben;
  endfunction

endpackage

// File: rtl/cf_sram_init_seq.sv
// -----------------------------------------------------------------------------
// cf_sram_init_seq
// Post-reset zeroing sweep: walks addresses 0..DEPTH-1, one per cycle, then
// raises init_done and stays idle until the next reset.
// Only instantiated when CF_SRAM_CTRL_INIT_EN is defined.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset (restarts sweep at address 0)
//   o_sweep_en     sweep write is active this cycle
//   o_sweep_ad     address being zeroed this cycle
//   o_sweep_last   this cycle writes the final address
//   o_init_done    sweep finished, SRAM contents are all zero
// -----------------------------------------------------------------------------
module cf_sram_init_seq
  import cf_sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              o_sweep_en,
  output logic [ADDR_W-1:0] o_sweep_ad,
  output logic              o_sweep_last,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_AD) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_sweep_en   = !r_done;
  assign o_sweep_ad   = r_cnt;
  assign o_sweep_last = !r_done && (r_cnt == LAST_AD);
  assign o_init_done  = r_done;

endmodule

// File: rtl/cf_sram_ctrl.sv
// -----------------------------------------------------------------------------
// cf_sram_ctrl
// Single-port controller for the CF_SRAM_1024x32 macro. A valid/ready request
// channel is converted combinationally into the macro command in the accept
// cycle; read data comes back on a valid/ready response channel with one cycle
// of latency. One response is held under backpressure by blocking new requests.
//
// Optional feature: define CF_SRAM_CTRL_INIT_EN to zero the whole array after
// every reset (INIT state, 1024 cycles) before accepting requests.
//
// Ports:
//   clk, rst                    clock (shared with macro CLKin), sync reset
//   req_valid/ready/we/addr/wdata/wstrb   request channel
//   rsp_valid/ready/rdata       read response channel
//   init_done                   SRAM usable
//   sram_en/r_wb/ad/ben/di/do   macro data path
//   sram_wlbi/sm/tm/scan_*      tied to 0
//   sram_vpwrac/vpwrpc          tied to 1
// -----------------------------------------------------------------------------
module cf_sram_ctrl #(
  parameter int ADDR_W = cf_sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = cf_sram_ctrl_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                sram_en,
  output logic                sram_r_wb,
  output logic [ADDR_W-1:0]   sram_ad,
  output logic [DATA_W-1:0]   sram_ben,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do,
  output logic                sram_wlbi,
  output logic                sram_sm,
  output logic                sram_tm,
  output logic                sram_scan_dr,
  output logic                sram_scan_dl,
  output logic                sram_scan_cc,
  output logic                sram_vpwrac,
  output logic                sram_vpwrpc
);

  import cf_sram_ctrl_pkg::state_t;
  import cf_sram_ctrl_pkg::INIT;
  import cf_sram_ctrl_pkg::RUN;
  import cf_sram_ctrl_pkg::strb_to_ben;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rsp_valid;
  logic              w_accept;
  logic              w_sweep_en;
  logic [ADDR_W-1:0] w_sweep_ad;
  logic              w_sweep_last;
  logic              w_init_done;

`ifdef CF_SRAM_CTRL_INIT_EN
  localparam state_t RESET_STATE = INIT;

  cf_sram_init_seq u_init_seq (
    .clk          (clk),
    .rst          (rst),
    .o_sweep_en   (w_sweep_en),
    .o_sweep_ad   (w_sweep_ad),
    .o_sweep_last (w_sweep_last),
    .o_init_done  (w_init_done)
  );
`else
  localparam state_t RESET_STATE = RUN;

  assign w_sweep_en   = 1'b0;
  assign w_sweep_ad   = '0;
  assign w_sweep_last = 1'b0;
  assign w_init_done  = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: INIT leaves together with the final sweep write, so RUN and
  // init_done rise on the same edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if (w_sweep_last) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Writes are blocked too while a response is stalled, so the macro never
  // sees a command that could disturb the held DO value.
  assign req_ready = w_init_done && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept && !req_we) begin
      r_rsp_valid <= 1'b1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Macro command mux: sweep during INIT, request on accept, idle otherwise.
  // The sweep is held off while rst is high so reset leaves the pins idle.
  always_comb begin
    sram_en   = 1'b0;
    sram_r_wb = 1'b1;
    sram_ad   = '0;
    sram_ben  = '0;
    sram_di   = '0;
    if ((r_state == INIT) && w_sweep_en && !rst) begin
      sram_en   = 1'b1;
      sram_r_wb = 1'b0;
      sram_ad   = w_sweep_ad;
      sram_ben  = '1;
    end else if (w_accept) begin
      sram_en   = 1'b1;
      sram_r_wb = !req_we;
      sram_ad   = req_addr;
      sram_di   = req_wdata;
      sram_ben  = req_we ? strb_to_ben(req_wstrb) : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = sram_do;
  assign init_done = w_init_done;

  assign sram_wlbi    = 1'b0;
  assign sram_sm      = 1'b0;
  assign sram_tm      = 1'b0;
  assign sram_scan_dr = 1'b0;
  assign sram_scan_dl = 1'b0;
  assign sram_scan_cc = 1'b0;
  assign sram_vpwrac  = 1'b1;
  assign sram_vpwrpc  = 1'b1;

endmodule
